// File: rtl/vga_frame_blitter.sv
// vga_frame_blitter
// Sweeps one H_RES x V_RES frame per falling V_SYNC edge. Each pixel address is
// issued to N_IMG parallel image ROMs that share one address bus. The (valid, x, y)
// tag of each pixel travels through a ROM_LAT-deep shift register so that it reaches
// the output stage together with the ROM data. The output stage selects one image
// slice, applies an optional square cursor overlay, and registers the VGA adapter
// write port.
module vga_frame_blitter #(
    parameter int                 H_RES      = 320,
    parameter int                 V_RES      = 240,
    parameter int                 X_W        = 9,
    parameter int                 Y_W        = 8,
    parameter int                 ADDR_W     = 17,
    parameter int                 COLOR_W    = 3,
    parameter int                 N_IMG      = 4,
    parameter int                 SEL_W      = 2,
    parameter int                 ROM_LAT    = 1,
    parameter int                 CURSOR_SZ  = 4,
    parameter logic [COLOR_W-1:0] CURSOR_COL = 3'b111
) (
    input  logic                     clk,
    input  logic                     iResetn,
    input  logic                     iVSync,
    input  logic [SEL_W-1:0]         iImgSel,
    input  logic                     iCursorEn,
    input  logic [X_W-1:0]           iMouseX,
    input  logic [Y_W-1:0]           iMouseY,
    output logic [ADDR_W-1:0]        oRomAddr,
    input  logic [N_IMG*COLOR_W-1:0] iRomData,
    output logic [X_W-1:0]           oX,
    output logic [Y_W-1:0]           oY,
    output logic [COLOR_W-1:0]       oColor,
    output logic                     oWriteEn,
    output logic                     oBusy,
    output logic                     oFrameDone,
    output logic                     oOverrun
);

    // Last coordinates of a frame, sized to the coordinate registers
    localparam logic [X_W-1:0] X_LAST = X_W'(H_RES - 1);
    localparam logic [Y_W-1:0] Y_LAST = Y_W'(V_RES - 1);

    // Drain counter must be able to count ROM_LAT-1
    localparam int DW = (ROM_LAT > 1) ? $clog2(ROM_LAT) : 1;
    localparam logic [DW-1:0] DRAIN_LAST = DW'(ROM_LAT - 1);

    // Cursor geometry in one-bit-wider arithmetic so mouse+size never wraps
    localparam bit              CUR_ON   = (CURSOR_SZ > 0);
    localparam logic [X_W:0]    CUR_W    = (X_W+1)'(CURSOR_SZ);
    localparam logic [Y_W:0]    CUR_H    = (Y_W+1)'(CURSOR_SZ);

    // Index of the pipeline stage that lines up with ROM data
    localparam int L = ROM_LAT - 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SWEEP = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t                 state;
    logic                   vsPrev;
    logic                   frameStart;

    // Frame parameters frozen at frame start
    logic [SEL_W-1:0]       selReg;
    logic                   curEnReg;
    logic [X_W-1:0]         mxReg;
    logic [Y_W-1:0]         myReg;

    // Sweep position and ROM address
    logic [X_W-1:0]         ax;
    logic [Y_W-1:0]         ay;
    logic [ADDR_W-1:0]      addrReg;
    logic [DW-1:0]          drainCnt;

    // Pixel tag shift register, aligned with ROM read latency
    logic                   pipeValid [ROM_LAT];
    logic [X_W-1:0]         pipeX     [ROM_LAT];
    logic [Y_W-1:0]         pipeY     [ROM_LAT];

    // Per-image colour slices of the ROM bus
    logic [COLOR_W-1:0]     imgPix    [N_IMG];

    logic [COLOR_W-1:0]     selPix;
    logic                   inCursor;
    logic [COLOR_W-1:0]     pixColor;

    assign frameStart = vsPrev & ~iVSync;
    assign oRomAddr   = addrReg;
    assign oBusy      = (state != IDLE);

    // Split the shared ROM data bus into one colour word per image
    genvar gi;
    generate
        for (gi = 0; gi < N_IMG; gi++) begin : g_slice
            assign imgPix[gi] = iRomData[gi*COLOR_W +: COLOR_W];
        end
    endgenerate

    // Sweep controller: frame-start detection, parameter latch, address generation
    always_ff @(posedge clk or negedge iResetn) begin
        if (!iResetn) begin
            state    <= IDLE;
            vsPrev   <= 1'b0;
            selReg   <= '0;
            curEnReg <= 1'b0;
            mxReg    <= '0;
            myReg    <= '0;
            ax       <= '0;
            ay       <= '0;
            addrReg  <= '0;
            drainCnt <= '0;
        end else begin
            vsPrev <= iVSync;
            case (state)
                IDLE: begin
                    if (frameStart) begin
                        state    <= SWEEP;
                        selReg   <= iImgSel;
                        curEnReg <= iCursorEn;
                        mxReg    <= iMouseX;
                        myReg    <= iMouseY;
                        ax       <= '0;
                        ay       <= '0;
                        addrReg  <= '0;
                    end
                end
                SWEEP: begin
                    if (ax == X_LAST) begin
                        ax <= '0;
                        if (ay == Y_LAST) begin
                            // Final address has just been issued; hold it, let the pipe empty
                            state    <= DRAIN;
                            drainCnt <= '0;
                        end else begin
                            ay      <= ay + 1'b1;
                            addrReg <= addrReg + 1'b1;
                        end
                    end else begin
                        ax      <= ax + 1'b1;
                        addrReg <= addrReg + 1'b1;
                    end
                end
                DRAIN: begin
                    if (drainCnt == DRAIN_LAST) begin
                        state <= IDLE;
                    end else begin
                        drainCnt <= drainCnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Tag pipeline: a valid tag enters for every address issued during SWEEP
    always_ff @(posedge clk or negedge iResetn) begin
        if (!iResetn) begin
            for (int i = 0; i < ROM_LAT; i++) begin
                pipeValid[i] <= 1'b0;
                pipeX[i]     <= '0;
                pipeY[i]     <= '0;
            end
        end else begin
            pipeValid[0] <= (state == SWEEP);
            pipeX[0]     <= ax;
            pipeY[0]     <= ay;
            for (int i = 1; i < ROM_LAT; i++) begin
                pipeValid[i] <= pipeValid[i-1];
                pipeX[i]     <= pipeX[i-1];
                pipeY[i]     <= pipeY[i-1];
            end
        end
    end

    // Pick the latched image; out-of-range selects produce black
    always_comb begin
        selPix = '0;
        for (int i = 0; i < N_IMG; i++) begin
            if (selReg == SEL_W'(i)) begin
                selPix = imgPix[i];
            end
        end
    end

    // Cursor hit test, clipped naturally because x/y never leave the screen
    always_comb begin
        inCursor = 1'b0;
        if (CUR_ON && curEnReg) begin
            inCursor = ({1'b0, pipeX[L]} >= {1'b0, mxReg}) &&
                       ({1'b0, pipeX[L]} <  ({1'b0, mxReg} + CUR_W)) &&
                       ({1'b0, pipeY[L]} >= {1'b0, myReg}) &&
                       ({1'b0, pipeY[L]} <  ({1'b0, myReg} + CUR_H));
        end
        pixColor = inCursor ? CURSOR_COL : selPix;
    end

    // Registered write port plus end-of-frame and dropped-start pulses
    always_ff @(posedge clk or negedge iResetn) begin
        if (!iResetn) begin
            oWriteEn   <= 1'b0;
            oX         <= '0;
            oY         <= '0;
            oColor     <= '0;
            oFrameDone <= 1'b0;
            oOverrun   <= 1'b0;
        end else begin
            oWriteEn   <= pipeValid[L];
            oX         <= pipeX[L];
            oY         <= pipeY[L];
            oColor     <= pipeValid[L] ? pixColor : '0;
            oFrameDone <= oWriteEn && (oX == X_LAST) && (oY == Y_LAST);
            oOverrun   <= frameStart && (state != IDLE);
        end
    end

endmodule
